// File: rtl/echo_receiver.sv
// echo_receiver: after an arm request, timestamps the first synchronized rising
// edge on each echo comparator line. It then streams the per-element results
// out over a valid/ready handshake.
module echo_receiver #(
    parameter int unsigned NUM_ELEMENTS = 64,
    parameter int unsigned DW_TOF       = 16,
    localparam int unsigned IDX_W       = $clog2(NUM_ELEMENTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DW_TOF-1:0]       max_cycles,
    input  logic [NUM_ELEMENTS-1:0] rxArray,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_index,
    output logic [DW_TOF-1:0]       out_tof,
    output logic                    out_hit,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LISTEN  = 2'd1,
        READOUT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_ELEMENTS-1:0]  sync1_q, sync2_q, prev_q, rise;
    logic [NUM_ELEMENTS-1:0]  hit_q, hit_d;
    logic [DW_TOF-1:0]        tof_q [NUM_ELEMENTS];
    logic [DW_TOF-1:0]        tof_d [NUM_ELEMENTS];
    logic [DW_TOF-1:0]        cnt_q, cnt_d, max_q, max_d;
    logic [IDX_W-1:0]         out_index_q, out_index_d, next_index;
    logic [DW_TOF-1:0]        out_tof_q, out_tof_d;
    logic                     out_hit_q, out_hit_d;
    logic                     busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;

    assign rise       = sync2_q & ~prev_q;
    assign next_index = out_index_q + IDX_W'(1);

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_tof   = out_tof_q;
    assign out_hit   = out_hit_q;
    assign done      = done_q;

    // Two-flop synchronizer plus previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= rxArray;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Next-state, capture and readout logic; results for the first word see captures of the final listen cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        hit_d       = hit_q;
        tof_d       = tof_q;
        out_index_d = out_index_q;
        out_tof_d   = out_tof_q;
        out_hit_d   = out_hit_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    max_d = max_cycles;
                    cnt_d = '0;
                    hit_d = '0;
                    for (int n = 0; n < int'(NUM_ELEMENTS); n++) begin
                        tof_d[n] = '0;
                    end
                    if (max_cycles == '0) begin
                        state_d     = READOUT;
                        out_index_d = '0;
                        out_tof_d   = '1;
                        out_hit_d   = 1'b0;
                    end else begin
                        state_d = LISTEN;
                    end
                end
            end
            LISTEN: begin
                for (int n = 0; n < int'(NUM_ELEMENTS); n++) begin
                    if (rise[n] && !hit_q[n]) begin
                        hit_d[n] = 1'b1;
                        tof_d[n] = cnt_q;
                    end
                end
                if ((cnt_q == max_q - DW_TOF'(1)) || (&hit_d)) begin
                    state_d     = READOUT;
                    out_index_d = '0;
                    out_hit_d   = hit_d[0];
                    out_tof_d   = hit_d[0] ? tof_d[0] : '1;
                end else begin
                    cnt_d = cnt_q + DW_TOF'(1);
                end
            end
            READOUT: begin
                if (out_ready) begin
                    if (out_index_q == IDX_W'(NUM_ELEMENTS - 1)) begin
                        state_d = DONE;
                    end else begin
                        out_index_d = next_index;
                        out_hit_d   = hit_q[next_index];
                        out_tof_d   = hit_q[next_index] ? tof_q[next_index] : '1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == READOUT);
        done_d      = (state_d == DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            max_q       <= '0;
            hit_q       <= '0;
            for (int n = 0; n < int'(NUM_ELEMENTS); n++) begin
                tof_q[n] <= '0;
            end
            out_index_q <= '0;
            out_tof_q   <= '0;
            out_hit_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            hit_q       <= hit_d;
            tof_q       <= tof_d;
            out_index_q <= out_index_d;
            out_tof_q   <= out_tof_d;
            out_hit_q   <= out_hit_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_echo_receiver.sv
// Bench for echo_receiver: table of runs, scoreboard of expected result words.
`timescale 1ns/1ps
module tb_echo_receiver;

    localparam int unsigned N  = 64;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] max_cycles;
    logic [N-1:0]  rxArray;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    out_index;
    logic [DW-1:0] out_tof;
    logic          out_hit;
    logic          done;

    echo_receiver #(.NUM_ELEMENTS(N), .DW_TOF(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .max_cycles (max_cycles),
        .rxArray    (rxArray),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .out_tof    (out_tof),
        .out_hit    (out_hit),
        .done       (done)
    );

    typedef struct {
        logic [DW-1:0] maxc;
        logic [N-1:0]  pre;       // bits already high before start
        int            pre_drop;  // listen cycle where pre bits fall (-1 none)
        logic [N-1:0]  mask_a;    // bits set high during cycle cyc_a
        int            cyc_a;
        logic          hit_a;
        logic [DW-1:0] tof_a;
        logic [N-1:0]  mask_b;
        int            cyc_b;
        logic          hit_b;
        logic [DW-1:0] tof_b;
        int            lat;       // cycle index of first out_valid
        bit            rnd;       // random out_ready
    } vec_t;

    typedef struct {
        logic [5:0]    idx;
        logic [DW-1:0] tof;
        logic          hit;
    } exp_t;

    exp_t    sb[$];
    vec_t    vecs[8];
    int      total = 0;
    int      bad   = 0;
    bit      rnd_mode = 0;
    bit      stalled  = 0;
    logic [5:0]    h_idx;
    logic [DW-1:0] h_tof;
    logic          h_hit;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready, changed just after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at each falling edge: compares a word about to transfer, and hold-while-stalled.
    task automatic mon_step();
        exp_t e;
        if (out_valid) begin
            if (stalled) begin
                check("stall_hold", 32'({out_index, out_tof, out_hit}), 32'({h_idx, h_tof, h_hit}));
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_index", 32'(out_index), 32'(e.idx));
                    check("out_tof",   32'(out_tof),   32'(e.tof));
                    check("out_hit",   32'(out_hit),   32'(e.hit));
                end
                stalled = 0;
            end else begin
                stalled = 1;
                h_idx = out_index;
                h_tof = out_tof;
                h_hit = out_hit;
            end
        end else begin
            stalled = 0;
        end
    endtask

    task automatic run_case(input vec_t v);
        exp_t e;
        int   k;
        bit   seen;
        bit   finished;
        for (int i = 0; i < int'(N); i++) begin
            e.idx = 6'(i);
            e.hit = 1'b0;
            e.tof = '1;
            if (v.mask_b[i] && v.cyc_b >= 0) begin
                e.hit = v.hit_b;
                e.tof = v.hit_b ? v.tof_b : '1;
            end else if (v.mask_a[i] && v.cyc_a >= 0) begin
                e.hit = v.hit_a;
                e.tof = v.hit_a ? v.tof_a : '1;
            end
            sb.push_back(e);
        end
        rxArray  = v.pre;
        rnd_mode = v.rnd;
        stalled  = 0;
        repeat (4) @(negedge clk);
        start      = 1'b1;
        max_cycles = v.maxc;
        @(negedge clk);
        k = 0;
        seen = 0;
        finished = 0;
        while (!finished && k < 2000) begin
            if (k == v.pre_drop) rxArray = rxArray & ~v.pre;
            if (k == v.cyc_a)    rxArray = rxArray | v.mask_a;
            if (k == v.cyc_b)    rxArray = rxArray | v.mask_b;
            if (k == 2) begin
                start      = 1'b1;
                max_cycles = 16'd7;
            end else begin
                start = 1'b0;
            end
            if (k == 0) check("busy_after_start", 32'(busy), 32'(1));
            if (!seen && out_valid) begin
                check("first_valid_cycle", 32'(k), 32'(v.lat));
                seen = 1;
            end
            mon_step();
            if (done) begin
                check("valid_during_done", 32'(out_valid), 32'(0));
                finished = 1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!finished) check("done_timeout", 32'(0), 32'(1));
        check("sb_empty", 32'(sb.size()), 32'(0));
        sb.delete();
        start    = 1'b0;
        rnd_mode = 0;
        rxArray  = '0;
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        max_cycles = '0;
        rxArray    = '0;

        //       maxc     pre           drop  mask_a                 cyc  hit   tof     mask_b        cyc  hit   tof    lat  rnd
        vecs[0] = '{16'd100,  64'h0,        -1, 64'h20,                 10, 1'b1, 16'd12, 64'h0,        -1, 1'b0, 16'd0,  100, 1'b0};
        vecs[1] = '{16'd100,  64'h0,        -1, 64'h8000_0000_8000_0001, 20, 1'b1, 16'd22, 64'h0,       -1, 1'b0, 16'd0,  100, 1'b1};
        vecs[2] = '{16'd1000, 64'h0,        -1, {64{1'b1}},              7, 1'b1, 16'd9,  64'h0,        -1, 1'b0, 16'd0,  10,  1'b0};
        vecs[3] = '{16'd50,   64'h0,        -1, 64'h8,                  47, 1'b1, 16'd49, 64'h10,       48, 1'b0, 16'd0,  50,  1'b0};
        vecs[4] = '{16'd0,    64'h0,        -1, 64'h4,                   1, 1'b0, 16'd0,  64'h0,        -1, 1'b0, 16'd0,  0,   1'b0};
        vecs[5] = '{16'd5,    64'h0,        -1, 64'h100,                 2, 1'b1, 16'd4,  64'h200,       3, 1'b0, 16'd0,  5,   1'b1};
        vecs[6] = '{16'd100,  64'h10_0000,  10, 64'h10_0000,            15, 1'b1, 16'd17, 64'h0,        -1, 1'b0, 16'd0,  100, 1'b0};
        vecs[7] = '{16'd100,  64'h0,        -1, 64'h40,                  3, 1'b1, 16'd5,  64'h4000_0000_0000_0000, 30, 1'b1, 16'd32, 100, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({busy, out_valid, out_index, out_tof, out_hit, done}), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));

        // Abort a listen window with reset; nothing from it may leak into the next run.
        start      = 1'b1;
        max_cycles = 16'd100;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rxArray[9] = 1'b1;
            @(negedge clk);
        end
        check("busy_mid_listen", 32'(busy), 32'(1));
        rst = 1'b0;
        #1;
        check("reset_abort_outputs", 32'({busy, out_valid, out_index, out_tof, out_hit, done}), 32'(0));
        @(negedge clk);
        rst     = 1'b1;
        rxArray = '0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_case(vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/echo_receiver.md
# echo_receiver

Receive-side counterpart of the Transmitter. After a transmit event it listens on the 64-element echo comparator bus, records per element the time of flight (clock cycles from arming to the first synchronized rising edge), then streams the 64 results out serially with a valid/ready handshake. It sits between the transducer receive front-end and the downstream delay-checking and beamforming logic.

## Interface
- NUM_ELEMENTS, 64, number of transducer elements; index width is IDX_W = clog2(NUM_ELEMENTS).
- DW_TOF, 16, time-of-flight counter and result width.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  arm request; sampled only in IDLE.
- max_cycles  in  DW_TOF  listen window length in cycles; latched on accepted start.
- rxArray  in  NUM_ELEMENTS  per-element echo comparator outputs, asynchronous to clk.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result word.
- out_index  out  IDX_W  element index of current result.
- out_tof  out  DW_TOF  time of flight of current element.
- out_hit  out  1  1 = edge detected for this element within window.
- done  out  1  one-cycle pulse after the last result is transferred.

## Operation
- Each rxArray bit passes a 2-flop synchronizer (sync1, sync2) then a prev register; edge[n] = sync2[n] & ~prev[n]. Synchronizers and prev run in all states.
- Per element: hit flag and DW_TOF tof register.
- FSM states: IDLE, LISTEN, READOUT, DONE.
- IDLE: start=1 latches max_cycles, clears all hit flags and tof registers, clears cycle counter cnt to 0; next state LISTEN, or READOUT directly if max_cycles = 0.
- LISTEN: each cycle, every element with edge[n]=1 and hit[n]=0 sets hit[n] and tof[n] <= cnt; multiple elements may hit in the same cycle, each latches independently. Later edges on an already-hit element are ignored. cnt increments by 1 per LISTEN cycle.
- LISTEN exit to READOUT after the cycle with cnt = max_cycles-1 (edges in that cycle are captured), or earlier after the cycle in which the last unhit element becomes hit.
- A bit already high when LISTEN starts is not an edge; it is captured only after it falls and rises again.
- READOUT: out_valid=1, out_index starts at 0; out_tof = tof[out_index] if hit, else all ones; out_hit = hit[out_index]. On out_valid & out_ready, index increments; transfer of index NUM_ELEMENTS-1 moves to DONE. Outputs hold stable while out_ready=0.
- DONE: done=1 for one cycle, out_valid=0; next state IDLE.
- start is ignored while busy=1. Reset in any state aborts immediately; no done pulse.

## Timing
- Reset values: busy 0, out_valid 0, out_index 0, out_tof 0, out_hit 0, done 0; FSM IDLE; synchronizers, prev, hit, tof, cnt all 0.
- start sampled high at edge E: busy=1 and first LISTEN cycle (cnt=0) begin after E.
- Capture latency: rxArray first sampled high at the edge ending the LISTEN cycle with cnt=c is reported as tof = c+2.
- A 0-to-1 rxArray pulse must stay high for at least 2 clk cycles to be guaranteed detected.
- Window: LISTEN lasts exactly max_cycles cycles unless all elements hit earlier. cnt never exceeds max_cycles-1, so no wrap.
- First out_valid is asserted the cycle after the last LISTEN cycle. With out_ready held 1, READOUT takes NUM_ELEMENTS cycles; done pulses the following cycle; busy drops with done's falling edge (IDLE).
- max_cycles = 0: READOUT starts the cycle after start; all out_hit=0, out_tof all ones.

## Test plan
- Reset: drive rst=0 mid-LISTEN -> all outputs at reset values immediately; after release, start works normally and results match the new run only.
- Single element: max_cycles=100, rxArray[5] rises before the edge at cnt=10 -> index 5 reports tof=12, hit=1; all others hit=0, tof=0xFFFF; done after 64 transfers.
- Simultaneous edges: elements 0, 31, 63 rise in the same cycle (cnt=20) -> all three report tof=22.
- Early exit: all 64 bits rise at cnt=7 with max_cycles=1000 -> READOUT begins the cycle after cnt=9; every tof=9.
- Window boundary: max_cycles=50, element 3 edge detected at cnt=49 (hit, tof=49); element 4 edge would reach cnt=50 (hit=0). max_cycles=0 -> immediate readout, all hit=0.
- Backpressure: toggle out_ready randomly -> indices 0..63 each transferred exactly once in order with stable data while stalled. start pulses while busy ignored. Pre-armed high bit not captured until re-rise.
